// File: rtl/multicycle_seq_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: state codes, opcode
// and funct3 values, PC-select and trap-cause codes, and opcode class indices.
package multicycle_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_FETCH  = 3'd0,
    SEQ_DECODE = 3'd1,
    SEQ_EXEC   = 3'd2,
    SEQ_MEM    = 3'd3,
    SEQ_WB     = 3'd4,
    SEQ_TRAP   = 3'd5
  } seq_state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] PCSEL_PC4  = 2'b00;
  localparam logic [1:0] PCSEL_IMM  = 2'b01;
  localparam logic [1:0] PCSEL_JALR = 2'b10;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_ILLEGAL  = 2'b01;
  localparam logic [1:0] TRAP_IMEM_TMO = 2'b10;
  localparam logic [1:0] TRAP_DMEM_TMO = 2'b11;

  // One-hot opcode class vector layout
  localparam int CLS_W       = 10;
  localparam int CLS_LUI     = 9;
  localparam int CLS_AUIPC   = 8;
  localparam int CLS_JAL     = 7;
  localparam int CLS_JALR    = 6;
  localparam int CLS_BR      = 5;
  localparam int CLS_LD      = 4;
  localparam int CLS_ST      = 3;
  localparam int CLS_OPI     = 2;
  localparam int CLS_OP      = 1;
  localparam int CLS_ILLEGAL = 0;

  // Branch condition from funct3 and the ALU compare flags; unknown funct3 is not taken
  function automatic logic br_taken(input logic [2:0] f3, input logic zero,
                                    input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  return zero;
      F3_BNE:  return ~zero;
      F3_BLT:  return lt;
      F3_BGE:  return ~lt;
      F3_BLTU: return ltu;
      F3_BGEU: return ~ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_seq_opclass.sv
// Combinational opcode classifier: maps IR[6:0] onto a one-hot class vector.
module multicycle_seq_opclass
  import multicycle_seq_pkg::*;
(
  input  logic [6:0]       opcode,
  output logic [CLS_W-1:0] cls
);

  // Exactly one class bit is set; anything unrecognised is illegal
  always_comb begin
    cls = '0;
    case (opcode)
      OPC_LUI:    cls[CLS_LUI]     = 1'b1;
      OPC_AUIPC:  cls[CLS_AUIPC]   = 1'b1;
      OPC_JAL:    cls[CLS_JAL]     = 1'b1;
      OPC_JALR:   cls[CLS_JALR]    = 1'b1;
      OPC_BRANCH: cls[CLS_BR]      = 1'b1;
      OPC_LOAD:   cls[CLS_LD]      = 1'b1;
      OPC_STORE:  cls[CLS_ST]      = 1'b1;
      OPC_OPIMM:  cls[CLS_OPI]     = 1'b1;
      OPC_OP:     cls[CLS_OP]      = 1'b1;
      default:    cls[CLS_ILLEGAL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with
// datapath strobes, memory handshakes, retired-instruction counter, and a
// sticky trap for illegal opcodes or memory ready timeouts.
module multicycle_seq
  import multicycle_seq_pkg::*;
#(
  parameter int RFIDX_W   = 5,
  parameter int INSTRET_W = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [RFIDX_W-1:0]   rd,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 ltu,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 reg_write,
  output logic                 pc_write,
  output logic [1:0]           pc_sel,
  output logic [2:0]           state,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  // Counter only needs to reach TIMEOUT-1 before the trap fires
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  seq_state_t           state_q, state_nxt;
  logic [TMO_W-1:0]     tmo_cnt_q;
  logic [INSTRET_W-1:0] instret_q;
  logic                 trap_q;
  logic [1:0]           trap_cause_q, trap_cause_nxt;
  logic [CLS_W-1:0]     cls;
  logic                 stalled;
  logic                 tmo_hit;
  logic                 to_wb;

  multicycle_seq_opclass u_opclass (
    .opcode (opcode),
    .cls    (cls)
  );

  assign stalled = ((state_q == SEQ_FETCH) && !imem_ready) ||
                   ((state_q == SEQ_MEM)   && !dmem_ready);

  // Current ready-low cycle is the TIMEOUT-th consecutive one
  assign tmo_hit = (TIMEOUT != 0) && (int'(tmo_cnt_q) == TIMEOUT - 1);

  // Classes that finish through a plain writeback step
  assign to_wb = cls[CLS_LUI] | cls[CLS_AUIPC] | cls[CLS_JAL] |
                 cls[CLS_JALR] | cls[CLS_OPI] | cls[CLS_OP];

  // Next-state and per-state strobes; a ready in the last allowed cycle beats the timeout
  always_comb begin
    state_nxt      = state_q;
    trap_cause_nxt = TRAP_NONE;
    imem_req       = 1'b0;
    ir_write       = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    reg_write      = 1'b0;
    pc_write       = 1'b0;
    pc_sel         = PCSEL_PC4;
    retire         = 1'b0;
    case (state_q)
      SEQ_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        if (imem_ready) begin
          state_nxt = SEQ_DECODE;
        end else if (tmo_hit) begin
          state_nxt      = SEQ_TRAP;
          trap_cause_nxt = TRAP_IMEM_TMO;
        end
      end
      SEQ_DECODE: begin
        if (cls[CLS_ILLEGAL]) begin
          state_nxt      = SEQ_TRAP;
          trap_cause_nxt = TRAP_ILLEGAL;
        end else begin
          state_nxt = SEQ_EXEC;
        end
      end
      SEQ_EXEC: begin
        if (cls[CLS_BR]) begin
          pc_write  = 1'b1;
          retire    = 1'b1;
          pc_sel    = br_taken(funct3, zero, lt, ltu) ? PCSEL_IMM : PCSEL_PC4;
          state_nxt = SEQ_FETCH;
        end else if (cls[CLS_LD] || cls[CLS_ST]) begin
          state_nxt = SEQ_MEM;
        end else if (to_wb) begin
          state_nxt = SEQ_WB;
        end else begin
          // IR changed under us after DECODE; halt rather than retire garbage
          state_nxt      = SEQ_TRAP;
          trap_cause_nxt = TRAP_ILLEGAL;
        end
      end
      SEQ_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls[CLS_ST];
        if (dmem_ready) begin
          if (cls[CLS_ST]) begin
            pc_write  = 1'b1;
            retire    = 1'b1;
            state_nxt = SEQ_FETCH;
          end else begin
            state_nxt = SEQ_WB;
          end
        end else if (tmo_hit) begin
          state_nxt      = SEQ_TRAP;
          trap_cause_nxt = TRAP_DMEM_TMO;
        end
      end
      SEQ_WB: begin
        reg_write = (rd != '0);
        pc_write  = 1'b1;
        retire    = 1'b1;
        if (cls[CLS_JAL]) begin
          pc_sel = PCSEL_IMM;
        end else if (cls[CLS_JALR]) begin
          pc_sel = PCSEL_JALR;
        end
        state_nxt = SEQ_FETCH;
      end
      SEQ_TRAP: begin
        state_nxt = SEQ_TRAP;
      end
      default: begin
        state_nxt = SEQ_FETCH;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_FETCH;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Consecutive ready-low counter, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_nxt != state_q) begin
      tmo_cnt_q <= '0;
    end else if (stalled && (TIMEOUT != 0)) begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  // Sticky trap flag and cause, captured on the edge entering TRAP
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q       <= 1'b0;
      trap_cause_q <= TRAP_NONE;
    end else if ((state_nxt == SEQ_TRAP) && (state_q != SEQ_TRAP)) begin
      trap_q       <= 1'b1;
      trap_cause_q <= trap_cause_nxt;
    end
  end

  assign state      = state_q;
  assign instret    = instret_q;
  assign trap       = trap_q;
  assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Directed bench for multicycle_seq: a per-cycle vector table for the
// instruction flows plus hand-written timeout and reset sequences.
module tb_multicycle_seq;

  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] OP   = 7'b0110011;
  localparam logic [6:0] BAD  = 7'b1111111;

  localparam logic [7:0] SF  = 8'b1100_0000; // fetch, word arriving
  localparam logic [7:0] SFW = 8'b1000_0000; // fetch, waiting
  localparam logic [7:0] S0  = 8'b0000_0000;
  localparam logic [7:0] SBR = 8'b0000_0110; // pc_write + retire
  localparam logic [7:0] SWB = 8'b0000_1110; // reg_write + pc_write + retire
  localparam logic [7:0] SLM = 8'b0010_0000; // load in MEM
  localparam logic [7:0] SSM = 8'b0011_0110; // store in MEM completing
  localparam logic [7:0] STR = 8'b0000_0001; // trapped

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        zero, lt, ltu, imem_ready, dmem_ready;
  logic        imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retire, trap;
  logic [1:0]  pc_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_seq #(.RFIDX_W(5), .INSTRET_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .rd(rd),
    .zero(zero), .lt(lt), .ltu(ltu), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write(reg_write), .pc_write(pc_write), .pc_sel(pc_sel), .state(state),
    .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [2:0]  flg;   // {zero, lt, ltu}
    logic        ir;
    logic        dr;
    logic [2:0]  st;
    logic [7:0]  strb;  // {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retire, trap}
    logic [1:0]  psel;
    logic [1:0]  tc;
    logic [31:0] ins;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string n, logic r, logic [6:0] o, logic [2:0] f, logic [4:0] d,
                              logic [2:0] fl, logic i, logic dm, logic [2:0] s, logic [7:0] sb,
                              logic [1:0] p, logic [1:0] t, logic [31:0] ni);
    vec_t v;
    v.name = n; v.rst = r; v.opc = o; v.f3 = f; v.rd = d; v.flg = fl; v.ir = i; v.dr = dm;
    v.st = s; v.strb = sb; v.psel = p; v.tc = t; v.ins = ni;
    return v;
  endfunction

  function automatic logic [7:0] strobes();
    return {imem_req, ir_write, dmem_req, dmem_we, reg_write, pc_write, retire, trap};
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", n, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [6:0] o, input logic [2:0] f, input logic [4:0] d,
                       input logic [2:0] fl, input logic i, input logic dm);
    rst = r; opcode = o; funct3 = f; rd = d;
    {zero, lt, ltu} = fl;
    imem_ready = i; dmem_ready = dm;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // name, rst, opc, f3, rd, flg, ir, dr, state, strobes, pc_sel, cause, instret
    tbl.push_back(mk("addi_F", 0, ADDI, 3'd0, 5'd1, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 0));
    tbl.push_back(mk("addi_D", 0, ADDI, 3'd0, 5'd1, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 0));
    tbl.push_back(mk("addi_E", 0, ADDI, 3'd0, 5'd1, 3'b000, 1, 1, 3'd2, S0,  2'd0, 2'd0, 0));
    tbl.push_back(mk("addi_W", 0, ADDI, 3'd0, 5'd1, 3'b000, 1, 1, 3'd4, SWB, 2'd0, 2'd0, 0));
    tbl.push_back(mk("beqT_F", 0, BR, 3'd0, 5'd0, 3'b100, 1, 1, 3'd0, SF,  2'd0, 2'd0, 1));
    tbl.push_back(mk("beqT_D", 0, BR, 3'd0, 5'd0, 3'b100, 1, 1, 3'd1, S0,  2'd0, 2'd0, 1));
    tbl.push_back(mk("beqT_E", 0, BR, 3'd0, 5'd0, 3'b100, 1, 1, 3'd2, SBR, 2'd1, 2'd0, 1));
    tbl.push_back(mk("beqN_F", 0, BR, 3'd0, 5'd0, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 2));
    tbl.push_back(mk("beqN_D", 0, BR, 3'd0, 5'd0, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 2));
    tbl.push_back(mk("beqN_E", 0, BR, 3'd0, 5'd0, 3'b000, 1, 1, 3'd2, SBR, 2'd0, 2'd0, 2));
    tbl.push_back(mk("bltu_F", 0, BR, 3'd6, 5'd0, 3'b001, 1, 1, 3'd0, SF,  2'd0, 2'd0, 3));
    tbl.push_back(mk("bltu_D", 0, BR, 3'd6, 5'd0, 3'b001, 1, 1, 3'd1, S0,  2'd0, 2'd0, 3));
    tbl.push_back(mk("bltu_E", 0, BR, 3'd6, 5'd0, 3'b001, 1, 1, 3'd2, SBR, 2'd1, 2'd0, 3));
    tbl.push_back(mk("bge_F",  0, BR, 3'd5, 5'd0, 3'b010, 1, 1, 3'd0, SF,  2'd0, 2'd0, 4));
    tbl.push_back(mk("bge_D",  0, BR, 3'd5, 5'd0, 3'b010, 1, 1, 3'd1, S0,  2'd0, 2'd0, 4));
    tbl.push_back(mk("bge_E",  0, BR, 3'd5, 5'd0, 3'b010, 1, 1, 3'd2, SBR, 2'd0, 2'd0, 4));
    tbl.push_back(mk("bne_F",  0, BR, 3'd1, 5'd0, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 5));
    tbl.push_back(mk("bne_D",  0, BR, 3'd1, 5'd0, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 5));
    tbl.push_back(mk("bne_E",  0, BR, 3'd1, 5'd0, 3'b000, 1, 1, 3'd2, SBR, 2'd1, 2'd0, 5));
    tbl.push_back(mk("lw_F",   0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd0, SF,  2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_D",   0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd1, S0,  2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_E",   0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd2, S0,  2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_M1",  0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd3, SLM, 2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_M2",  0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd3, SLM, 2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_M3",  0, LD, 3'd2, 5'd2, 3'b000, 1, 0, 3'd3, SLM, 2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_M4",  0, LD, 3'd2, 5'd2, 3'b000, 1, 1, 3'd3, SLM, 2'd0, 2'd0, 6));
    tbl.push_back(mk("lw_W",   0, LD, 3'd2, 5'd2, 3'b000, 1, 1, 3'd4, SWB, 2'd0, 2'd0, 6));
    tbl.push_back(mk("sw_F1",  0, ST, 3'd2, 5'd0, 3'b000, 0, 1, 3'd0, SFW, 2'd0, 2'd0, 7));
    tbl.push_back(mk("sw_F2",  0, ST, 3'd2, 5'd0, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 7));
    tbl.push_back(mk("sw_D",   0, ST, 3'd2, 5'd0, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 7));
    tbl.push_back(mk("sw_E",   0, ST, 3'd2, 5'd0, 3'b000, 1, 1, 3'd2, S0,  2'd0, 2'd0, 7));
    tbl.push_back(mk("sw_M",   0, ST, 3'd2, 5'd0, 3'b000, 1, 1, 3'd3, SSM, 2'd0, 2'd0, 7));
    tbl.push_back(mk("jal_F",  0, JAL, 3'd0, 5'd0, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 8));
    tbl.push_back(mk("jal_D",  0, JAL, 3'd0, 5'd0, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 8));
    tbl.push_back(mk("jal_E",  0, JAL, 3'd0, 5'd0, 3'b000, 1, 1, 3'd2, S0,  2'd0, 2'd0, 8));
    tbl.push_back(mk("jal_W",  0, JAL, 3'd0, 5'd0, 3'b000, 1, 1, 3'd4, SBR, 2'd1, 2'd0, 8));
    tbl.push_back(mk("jalr_F", 0, JALR, 3'd0, 5'd5, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 9));
    tbl.push_back(mk("jalr_D", 0, JALR, 3'd0, 5'd5, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 9));
    tbl.push_back(mk("jalr_E", 0, JALR, 3'd0, 5'd5, 3'b000, 1, 1, 3'd2, S0,  2'd0, 2'd0, 9));
    tbl.push_back(mk("jalr_W", 0, JALR, 3'd0, 5'd5, 3'b000, 1, 1, 3'd4, SWB, 2'd2, 2'd0, 9));
    tbl.push_back(mk("op_F",   0, OP, 3'd0, 5'd3, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 10));
    tbl.push_back(mk("op_D",   0, OP, 3'd0, 5'd3, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 10));
    tbl.push_back(mk("op_E",   0, OP, 3'd0, 5'd3, 3'b000, 1, 1, 3'd2, S0,  2'd0, 2'd0, 10));
    tbl.push_back(mk("op_W",   0, OP, 3'd0, 5'd3, 3'b000, 1, 1, 3'd4, SWB, 2'd0, 2'd0, 10));
    tbl.push_back(mk("ill_F",  0, BAD, 3'd0, 5'd0, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 11));
    tbl.push_back(mk("ill_D",  0, BAD, 3'd0, 5'd0, 3'b000, 1, 1, 3'd1, S0,  2'd0, 2'd0, 11));
    tbl.push_back(mk("ill_T1", 0, BAD, 3'd0, 5'd0, 3'b000, 1, 1, 3'd5, STR, 2'd0, 2'd1, 11));
    tbl.push_back(mk("ill_T2", 0, BAD, 3'd0, 5'd0, 3'b000, 1, 1, 3'd5, STR, 2'd0, 2'd1, 11));
    tbl.push_back(mk("ill_Tr", 1, BAD, 3'd0, 5'd0, 3'b000, 1, 1, 3'd5, STR, 2'd0, 2'd1, 11));
    tbl.push_back(mk("ill_R",  0, ADDI, 3'd0, 5'd1, 3'b000, 1, 1, 3'd0, SF,  2'd0, 2'd0, 0));

    drive(1, ADDI, 3'd0, 5'd1, 3'b000, 1, 1);
    repeat (2) @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].opc, tbl[k].f3, tbl[k].rd, tbl[k].flg, tbl[k].ir, tbl[k].dr);
      @(negedge clk);
      chk({tbl[k].name, "_out"}, {17'd0, state, strobes(), pc_sel, trap_cause},
          {17'd0, tbl[k].st, tbl[k].strb, tbl[k].psel, tbl[k].tc});
      chk({tbl[k].name, "_instret"}, instret, tbl[k].ins);
      edge1();
    end

    // imem timeout: four ready-low FETCH cycles then TRAP with cause 10
    drive(1, ADDI, 3'd0, 5'd1, 3'b000, 0, 1);
    edge1();
    for (int i = 0; i < 4; i++) begin
      drive(0, ADDI, 3'd0, 5'd1, 3'b000, 0, 1);
      @(negedge clk);
      chk($sformatf("itmo_c%0d_state", i), 32'(state), 32'd0);
      chk($sformatf("itmo_c%0d_req", i), 32'(imem_req), 32'd1);
      edge1();
    end
    @(negedge clk);
    chk("itmo_state", 32'(state), 32'd5);
    chk("itmo_trap", 32'(trap), 32'd1);
    chk("itmo_cause", 32'(trap_cause), 32'd2);
    chk("itmo_req", 32'(imem_req), 32'd0);

    // ready arriving in the 4th cycle wins over the timeout
    drive(1, ADDI, 3'd0, 5'd1, 3'b000, 0, 1);
    edge1();
    drive(0, ADDI, 3'd0, 5'd1, 3'b000, 0, 1);
    repeat (3) edge1();
    imem_ready = 1'b1;
    @(negedge clk);
    chk("irdy4_irw", 32'(ir_write), 32'd1);
    edge1();
    @(negedge clk);
    chk("irdy4_state", 32'(state), 32'd1);
    chk("irdy4_trap", 32'(trap), 32'd0);
    repeat (3) edge1();
    @(negedge clk);
    chk("irdy4_instret", instret, 32'd1);

    // reset in the middle of a MEM wait drops the request and clears instret
    drive(0, LD, 3'd2, 5'd2, 3'b000, 1, 0);
    repeat (4) edge1();
    @(negedge clk);
    chk("mrst_pre_state", 32'(state), 32'd3);
    chk("mrst_pre_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_state", 32'(state), 32'd0);
    chk("mrst_dreq", 32'(dmem_req), 32'd0);
    chk("mrst_instret", instret, 32'd0);

    // dmem timeout: four ready-low MEM cycles then TRAP with cause 11
    repeat (6) edge1();
    @(negedge clk);
    chk("dtmo_pre_state", 32'(state), 32'd3);
    chk("dtmo_pre_trap", 32'(trap), 32'd0);
    edge1();
    @(negedge clk);
    chk("dtmo_state", 32'(state), 32'd5);
    chk("dtmo_cause", 32'(trap_cause), 32'd3);
    chk("dtmo_dreq", 32'(dmem_req), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
